// File: rtl/dmem_responder_if.sv
// Data-port bundle between the CPU (master) and dmem_responder (slave).
// Request and response channels each use a valid/ready handshake.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// Fixed-latency data RAM responder, one request in flight at a time.
// Optional address checking is enabled by defining DMEM_ADDR_CHECK_EN.
module dmem_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic clk,
  input  logic rst,
  dmem_responder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = 4;
  localparam logic [CW-1:0] CNT_INIT = CW'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic          wr_q;
  logic          err_q;
  logic [AW-1:0] idx_q;
  logic [31:0]   wdata_q;
  logic          req_ready_q;
  logic          resp_valid_q;
  logic          resp_err_q;
  logic [31:0]   resp_rdata_q;
  logic [31:0]   mem [DEPTH];

  logic accept;
  logic fire;
  logic commit;
  logic addr_err;

  assign accept = req_ready_q & bus.req_valid;
  assign fire   = (state_q == WAIT) && (cnt_q == '0);
  assign commit = fire & wr_q & ~err_q & ~rst;

`ifdef DMEM_ADDR_CHECK_EN
  assign addr_err = (bus.req_addr[1:0] != 2'b00)
                  | (bus.req_addr[31:AW+2] != '0);
  assign bus.resp_err = resp_err_q;
`else
  logic unused_addr;
  assign unused_addr  = ^{bus.req_addr[31:AW+2],
                          bus.req_addr[1:0], resp_err_q};
  assign addr_err     = 1'b0;
  assign bus.resp_err = 1'b0;
`endif

  assign bus.req_ready  = req_ready_q;
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;

  // RAM has no reset; contents survive rst
  always_ff @(posedge clk) begin
    if (commit) begin
      mem[idx_q] <= wdata_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      wr_q         <= 1'b0;
      err_q        <= 1'b0;
      idx_q        <= '0;
      wdata_q      <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            wr_q        <= bus.req_write;
            err_q       <= addr_err;
            idx_q       <= bus.req_addr[AW+1:2];
            wdata_q     <= bus.req_wdata;
            cnt_q       <= CNT_INIT;
            req_ready_q <= 1'b0;
            state_q     <= WAIT;
          end
        end
        WAIT: begin
          if (cnt_q == '0) begin
            resp_valid_q <= 1'b1;
            resp_err_q   <= err_q;
            if (err_q) begin
              resp_rdata_q <= '0;
            end else if (wr_q) begin
              resp_rdata_q <= wdata_q;
            end else begin
              resp_rdata_q <= mem[idx_q];
            end
            state_q <= RESP;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        RESP: begin
          if (bus.resp_ready) begin
            resp_valid_q <= 1'b0;
            req_ready_q  <= 1'b1;
            state_q      <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed cases on a LATENCY=2 instance,
// random load/store sweep on a LATENCY=1 instance against an array model.
module tb_dmem_responder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_responder_if b0 ();
  dmem_responder_if b1 ();

  dmem_responder #(.DEPTH(256), .LATENCY(2)) u_dut0 (
    .clk (clk),
    .rst (rst),
    .bus (b0.slave)
  );

  dmem_responder #(.DEPTH(256), .LATENCY(1)) u_dut1 (
    .clk (clk),
    .rst (rst),
    .bus (b1.slave)
  );

  logic        sel;
  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_ready;

  assign b0.req_valid  = req_valid & ~sel;
  assign b1.req_valid  = req_valid & sel;
  assign b0.resp_ready = resp_ready & ~sel;
  assign b1.resp_ready = resp_ready & sel;
  assign b0.req_write  = req_write;
  assign b1.req_write  = req_write;
  assign b0.req_addr   = req_addr;
  assign b1.req_addr   = req_addr;
  assign b0.req_wdata  = req_wdata;
  assign b1.req_wdata  = req_wdata;

  wire        req_ready  = sel ? b1.req_ready  : b0.req_ready;
  wire        resp_valid = sel ? b1.resp_valid : b0.resp_valid;
  wire [31:0] resp_rdata = sel ? b1.resp_rdata : b0.resp_rdata;
  wire        resp_err   = sel ? b1.resp_err   : b0.resp_err;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] ref_mem [256];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One full transaction: accept, wait, optional backpressure, retire
  task automatic txn(input  logic        w,
                     input  logic [31:0] a,
                     input  logic [31:0] d,
                     input  int          hold,
                     input  int          lat_exp,
                     output logic [31:0] rd,
                     output logic        e);
    int n;
    @(negedge clk);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("req_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    n = 0;
    while (resp_valid !== 1'b1 && n < 40) begin
      chk("busy_rdy", 32'(req_ready), 32'd0);
      @(posedge clk);
      #1;
      n++;
    end
    chk("lat", 32'(n), 32'(lat_exp));
    chk("resp_rdy", 32'(req_ready), 32'd0);
    rd = resp_rdata;
    e  = resp_err;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk("hold_vld", 32'(resp_valid), 32'd1);
      chk("hold_data", resp_rdata, rd);
      chk("hold_rdy", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    chk("done_vld", 32'(resp_valid), 32'd0);
    chk("done_rdy", 32'(req_ready), 32'd1);
    chk("done_keep", resp_rdata, rd);
  endtask

  function automatic logic [31:0] mkaddr(input logic [7:0] idx);
    logic [31:0] r;
    r = $urandom();
`ifdef DMEM_ADDR_CHECK_EN
    r = 32'd0;
`endif
    return {r[31:10], idx, r[1:0]};
  endfunction

  logic [31:0] rd;
  logic        e;

  initial begin
    rst        = 1'b1;
    sel        = 1'b0;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdy", 32'(req_ready), 32'd1);
    chk("rst_vld", 32'(resp_valid), 32'd0);
    chk("rst_data", resp_rdata, 32'd0);
    chk("rst_err", 32'(resp_err), 32'd0);
    rst = 1'b0;

    // Reset mid-WAIT drops the store
    txn(1'b1, 32'h10, 32'h1111_1111, 0, 2, rd, e);
    chk("t1_echo", rd, 32'h1111_1111);
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h10;
    req_wdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1 req_valid = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("t1_rdy", 32'(req_ready), 32'd1);
    chk("t1_vld", 32'(resp_valid), 32'd0);
    txn(1'b0, 32'h10, 32'h0, 0, 2, rd, e);
    chk("t1_load", rd, 32'h1111_1111);

    // Store/load round trip
    txn(1'b1, 32'h40, 32'h1234_5678, 0, 2, rd, e);
    chk("t2_echo", rd, 32'h1234_5678);
    txn(1'b0, 32'h40, 32'h0, 0, 2, rd, e);
    chk("t2_load", rd, 32'h1234_5678);

    // Backpressure
    txn(1'b0, 32'h40, 32'h0, 5, 2, rd, e);
    chk("t3_load", rd, 32'h1234_5678);

`ifdef DMEM_ADDR_CHECK_EN
    txn(1'b1, 32'h0, 32'h5A5A_5A5A, 0, 2, rd, e);
    chk("t5_seed_err", 32'(e), 32'd0);
    txn(1'b0, 32'h402, 32'h0, 0, 2, rd, e);
    chk("t5_ld_err", 32'(e), 32'd1);
    chk("t5_ld_data", rd, 32'd0);
    txn(1'b1, 32'h400, 32'hFFFF_FFFF, 0, 2, rd, e);
    chk("t5_st_err", 32'(e), 32'd1);
    chk("t5_st_data", rd, 32'd0);
    txn(1'b0, 32'h0, 32'h0, 0, 2, rd, e);
    chk("t5_ram0", rd, 32'h5A5A_5A5A);
    chk("t5_ram0_err", 32'(e), 32'd0);
    txn(1'b0, 32'h3FC, 32'h0, 0, 2, rd, e);
    chk("t5_top_err", 32'(e), 32'd0);
`else
    txn(1'b1, 32'h400, 32'hA5A5_A5A5, 0, 2, rd, e);
    chk("t4_st_err", 32'(e), 32'd0);
    txn(1'b0, 32'h0, 32'h0, 0, 2, rd, e);
    chk("t4_wrap", rd, 32'hA5A5_A5A5);
    chk("t4_err", 32'(e), 32'd0);
`endif

    // Random sweep on the LATENCY=1 instance
    sel = 1'b1;
    for (int i = 0; i < 16; i++) begin
      logic [31:0] d;
      d = $urandom();
      ref_mem[i] = d;
      txn(1'b1, mkaddr(8'(i)), d, 0, 1, rd, e);
      chk("seed_echo", rd, d);
    end
    for (int i = 0; i < 100; i++) begin
      logic [7:0]  si;
      logic [7:0]  li;
      logic [31:0] d;
      si = 8'($urandom_range(0, 15));
      li = 8'($urandom_range(0, 15));
      d  = $urandom();
      txn(1'b1, mkaddr(si), d, $urandom_range(0, 2), 1, rd, e);
      ref_mem[si] = d;
      chk("sw_echo", rd, d);
      txn(1'b0, mkaddr(li), 32'h0, $urandom_range(0, 2), 1, rd, e);
      chk("sw_load", rd, ref_mem[li]);
      chk("sw_err", 32'(e), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
